serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin one subtraction.
REQ-005 SHALL have port a, input, NUM_BITS, the minuend, unsigned or two's complement.
REQ-006 SHALL have port b, input, NUM_BITS, the subtrahend.
REQ-007 SHALL have port borrow_in, input, 1, the borrow subtracted from a-b.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse marking fresh results.
REQ-010 SHALL have port diff, output, NUM_BITS, the registered result of (a - b - borrow_in) mod 2^NUM_BITS.
REQ-011 SHALL have port borrow_out, output, 1, the registered unsigned underflow flag, 1 iff a < b + borrow_in.
REQ-012 SHALL have port overflow, output, 1, the registered signed overflow flag, 1 iff a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-014 IDLE: busy=0 and done=0; start=1 at an edge captures a, b and borrow_in into internal registers, clears the bit counter, and moves to SHIFT.
REQ-015 SHIFT: busy=1 and done=0; each cycle SHALL process exactly one bit, LSB first, using a single 1-bit full-subtractor: d = x ^ y ^ br; br_next = (~x & y) | (~(x ^ y) & br).
REQ-016 SHIFT SHALL last exactly NUM_BITS cycles; at the edge completing bit NUM_BITS-1, diff, borrow_out (the final br) and overflow SHALL load together and the FSM SHALL move to DONE.
REQ-017 DONE: busy=0 and done=1 for exactly one cycle, then the FSM returns to IDLE; if start=1 in DONE, the request SHALL be accepted as in IDLE (back-to-back operation, moving directly to SHIFT).
REQ-018 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E(NUM_BITS), i.e. NUM_BITS+1 cycles from acceptance to the done cycle inclusive.
REQ-019 start SHALL be ignored while in SHIFT; changes on a, b and borrow_in after capture SHALL NOT affect the operation in progress.
REQ-020 diff, borrow_out and overflow SHALL hold their last loaded values until the next operation completes; they SHALL never show partial results.
REQ-021 The bit counter SHALL be ceil(log2(NUM_BITS))+1 bits wide and SHALL NOT wrap mid-operation.

Reset
REQ-022 With rst=1 at an edge: state goes to IDLE; busy, done, diff, borrow_out and overflow go to 0; the counter and operand registers are cleared.
REQ-023 rst SHALL take priority over start and over any state; reset during SHIFT aborts the operation with no done pulse and leaves the outputs at 0.
REQ-024 start held high during reset SHALL NOT be accepted until the first edge with rst=0.

Verification (NUM_BITS=8)
REQ-025 a=0x05, b=0x03, bin=0, pulse start -> done 9 cycles later inclusive; diff=0x02, borrow_out=0, overflow=0.
REQ-026 a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow_out=1, overflow=0; a=0x80, b=0x01, bin=0 -> diff=0x7F, borrow_out=0, overflow=1.
REQ-027 a=0x7F, b=0xFF, bin=1 -> diff=0x7F, borrow_out=1, overflow=0; start re-pulsed and a changed to 0x00 during SHIFT -> result unchanged, still exactly one done pulse.
REQ-028 rst asserted 3 cycles into SHIFT -> next cycle busy=0, diff=0x00, no done pulse ever seen; a fresh start then yields a correct result.
REQ-029 start held high continuously -> done pulses every 9 cycles, busy low only during the DONE cycles.
REQ-030 Exhaustive sweep of all 131072 {a, b, bin} combinations -> every diff, borrow_out and overflow matches the reference model {borrow, diff} = a - b - bin, with no mismatch errors.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor bit per clock, LSB first, with
// registered difference, unsigned borrow and signed overflow results.
//
//   state | meaning
//   IDLE  | waiting for start; results hold last completed operation
//   SHIFT | processing one operand bit per cycle, NUM_BITS cycles
//   DONE  | one-cycle done pulse; start here begins the next operation
module serial_subtractor #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                borrow_out,
  output logic                overflow
);

  localparam int CW = $clog2(NUM_BITS) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       cnt;
  logic [NUM_BITS-1:0] x_sr, y_sr, d_sr;
  logic [NUM_BITS-1:0] diff_final;
  logic                br, a_msb, b_msb;
  logic                accept, last_bit, d_bit, br_next;

  assign last_bit   = (cnt == CW'(NUM_BITS - 1));
  assign d_bit      = x_sr[0] ^ y_sr[0] ^ br;
  assign br_next    = (~x_sr[0] & y_sr[0]) | (~(x_sr[0] ^ y_sr[0]) & br);
  assign diff_final = {d_bit, d_sr[NUM_BITS-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Difference bits enter at the top of d_sr so the word is aligned after the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      x_sr       <= '0;
      y_sr       <= '0;
      d_sr       <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      x_sr  <= a;
      y_sr  <= b;
      d_sr  <= '0;
      br    <= borrow_in;
      a_msb <= a[NUM_BITS-1];
      b_msb <= b[NUM_BITS-1];
    end else if (state == SHIFT) begin
      x_sr <= x_sr >> 1;
      y_sr <= y_sr >> 1;
      d_sr <= diff_final;
      br   <= br_next;
      if (last_bit) begin
        diff       <= diff_final;
        borrow_out <= br_next;
        overflow   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner vectors, reset
// abort, continuous start and randomized operands against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, borrow_in;
  logic [W-1:0] a, b, diff;
  logic         busy, done, borrow_out, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.NUM_BITS(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {overflow, borrow, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                         input logic xbin);
    int          full;
    logic [31:0] full_bits;
    logic [W-1:0] d;
    logic        brw, ovf;
    full      = int'(xa) - int'(xb) - int'(xbin);
    full_bits = full;
    d         = full_bits[W-1:0];
    brw       = (full < 0);
    ovf       = (xa[W-1] != xb[W-1]) && (d[W-1] != xa[W-1]);
    return {ovf, brw, d};
  endfunction

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                        input bit disturb, input string tag);
    logic [W+1:0] exp;
    int           lat;
    exp       = model(xa, xb, xbin);
    a         = xa;
    b         = xb;
    borrow_in = xbin;
    start     = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 3 * W) begin
      if (disturb && lat == 2) begin
        start     = 1'b1;
        a         = '0;
        b         = ~xb;
        borrow_in = ~xbin;
      end
      if (disturb && lat == 3) start = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, W);
    check({tag, "_diff"}, diff, exp[W-1:0]);
    check({tag, "_borrow"}, borrow_out, exp[W]);
    check({tag, "_ovf"}, overflow, exp[W+1]);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    tick();
    check({tag, "_done_width"}, done, 1'b0);
    check({tag, "_diff_hold"}, diff, exp[W-1:0]);
  endtask

  initial begin
    int pulses, bad;
    rst       = 1'b1;
    start     = 1'b1;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_borrow", borrow_out, 1'b0);
    check("rst_ovf", overflow, 1'b0);

    // start held through reset is taken at the first edge without reset
    rst = 1'b0;
    tick();
    check("start_after_rst", busy, 1'b1);
    start = 1'b0;
    repeat (W + 2) tick();

    run_op(8'h05, 8'h03, 1'b0, 1'b0, "v1");
    run_op(8'h00, 8'h01, 1'b0, 1'b0, "v2");
    run_op(8'h80, 8'h01, 1'b0, 1'b0, "v3");
    run_op(8'h7F, 8'hFF, 1'b1, 1'b1, "v4_disturb");

    // reset three cycles into SHIFT aborts with cleared outputs
    a = 8'h55; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_diff", diff, 8'h00);
    check("abort_borrow", borrow_out, 1'b0);
    pulses = 0;
    repeat (15) begin
      if (done) pulses++;
      tick();
    end
    check("abort_no_done", pulses, 0);
    run_op(8'h55, 8'h11, 1'b0, 1'b0, "after_abort");

    // continuous start: done every W+1 cycles, busy low exactly in done cycles
    a = 8'h05; b = 8'h03; borrow_in = 1'b0; start = 1'b1;
    tick();
    pulses = 0;
    bad    = 0;
    for (int cyc = 0; cyc < 5 * (W + 1); cyc++) begin
      if (done != ((cyc % (W + 1)) == W)) bad++;
      if (busy == done) bad++;
      if (done) begin
        pulses++;
        if (diff != 8'h02) bad++;
      end
      tick();
    end
    check("cont_pattern_errs", bad, 0);
    check("cont_pulses", pulses, 5);
    start = 1'b0;
    repeat (W + 3) tick();
    check("cont_drain_idle", busy, 1'b0);

    run_op(8'hFF, 8'h00, 1'b1, 1'b0, "edge_ff");
    run_op(8'h00, 8'hFF, 1'b1, 1'b0, "edge_00");
    run_op(8'h80, 8'h7F, 1'b0, 1'b0, "edge_80");

    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      ra   = W'($urandom_range(0, (1 << W) - 1));
      rb   = W'($urandom_range(0, (1 << W) - 1));
      rbin = 1'($urandom_range(0, 1));
      run_op(ra, rb, rbin, (i % 7) == 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
